// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: pin conditioning, 11-bit frame deserializer,
// odd-parity / stop-bit checking and E0/F0 prefix folding into event flags.
// Optional build macro PS2_TIMEOUT_EN adds a mid-frame inactivity abort.
module ps2_rx #(
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       is_ext,
    output logic       is_break,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int unsigned FW = 4;
    localparam int unsigned BW = 3;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] STOP   = 2'd3;

    localparam logic [7:0] BYTE_EXT = 8'hE0;
    localparam logic [7:0] BYTE_BRK = 8'hF0;

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic [FW-1:0] flt_cnt;
    logic          clk_filt;
    logic          clk_filt_d;
    logic          fall_c;
    logic          din_c;

    logic [1:0]    state,      state_n;
    logic [BW-1:0] bit_cnt,    bit_cnt_n;
    logic [7:0]    shift,      shift_n;
    logic          par,        par_n;
    logic          ext_pend,   ext_pend_n;
    logic          brk_pend,   brk_pend_n;
    logic [7:0]    code_n;
    logic          code_valid_n;
    logic          is_ext_n;
    logic          is_break_n;
    logic          parity_err_n;
    logic          frame_err_n;

    // Two-flop synchronizers; pins idle high so reset to 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // Clock deglitch: level flips only after FILTER_LEN consecutive differing samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flt_cnt    <= '0;
            clk_filt   <= 1'b1;
            clk_filt_d <= 1'b1;
        end else begin
            clk_filt_d <= clk_filt;
            if (clk_sync[1] == clk_filt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_sync[1];
                flt_cnt  <= '0;
            end else begin
                flt_cnt <= FW'(flt_cnt + FW'(1));
            end
        end
    end

    // One-cycle sample strobe on the registered filtered falling edge
    assign fall_c = clk_filt_d & ~clk_filt;
    assign din_c  = data_sync[1];

`ifdef PS2_TIMEOUT_EN
    localparam int unsigned TOW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TOW-1:0] to_cnt;
    logic           to_hit_c;

    // Inactivity counter, running only while a frame is in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (state == IDLE || fall_c) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= TOW'(to_cnt + TOW'(1));
        end
    end

    assign to_hit_c = (state != IDLE) && !fall_c && (to_cnt == TOW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Frame FSM next-state and output decode
    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        shift_n      = shift;
        par_n        = par;
        ext_pend_n   = ext_pend;
        brk_pend_n   = brk_pend;
        code_n       = code;
        is_ext_n     = is_ext;
        is_break_n   = is_break;
        code_valid_n = 1'b0;
        parity_err_n = 1'b0;
        frame_err_n  = 1'b0;

        case (state)
            IDLE: begin
                if (fall_c && !din_c) begin
                    bit_cnt_n = '0;
                    state_n   = DATA;
                end
            end
            DATA: begin
                if (fall_c) begin
                    shift_n   = {din_c, shift[7:1]};
                    bit_cnt_n = BW'(bit_cnt + BW'(1));
                    if (bit_cnt == BW'(7)) begin
                        state_n = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall_c) begin
                    par_n   = din_c;
                    state_n = STOP;
                end
            end
            STOP: begin
                if (fall_c) begin
                    state_n = IDLE;
                    if (!din_c) begin
                        frame_err_n = 1'b1;
                        ext_pend_n  = 1'b0;
                        brk_pend_n  = 1'b0;
                    end else if (!(^{shift, par})) begin
                        parity_err_n = 1'b1;
                        ext_pend_n   = 1'b0;
                        brk_pend_n   = 1'b0;
                    end else if (shift == BYTE_EXT) begin
                        ext_pend_n = 1'b1;
                    end else if (shift == BYTE_BRK) begin
                        brk_pend_n = 1'b1;
                    end else begin
                        code_n       = shift;
                        is_ext_n     = ext_pend;
                        is_break_n   = brk_pend;
                        code_valid_n = 1'b1;
                        ext_pend_n   = 1'b0;
                        brk_pend_n   = 1'b0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

`ifdef PS2_TIMEOUT_EN
        if (to_hit_c) begin
            state_n     = IDLE;
            frame_err_n = 1'b1;
            ext_pend_n  = 1'b0;
            brk_pend_n  = 1'b0;
        end
`endif
    end

    // FSM state, datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            par        <= 1'b0;
            ext_pend   <= 1'b0;
            brk_pend   <= 1'b0;
            code       <= '0;
            is_ext     <= 1'b0;
            is_break   <= 1'b0;
            code_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shift      <= shift_n;
            par        <= par_n;
            ext_pend   <= ext_pend_n;
            brk_pend   <= brk_pend_n;
            code       <= code_n;
            is_ext     <= is_ext_n;
            is_break   <= is_break_n;
            code_valid <= code_valid_n;
            parity_err <= parity_err_n;
            frame_err  <= frame_err_n;
        end
    end

endmodule

// File: tb/tb_ps2_rx.sv
// Randomized self-checking bench for ps2_rx against a frame-level event model.
module tb_ps2_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] code;
    logic       code_valid;
    logic       is_ext;
    logic       is_break;
    logic       parity_err;
    logic       frame_err;

    int total = 0;
    int bad = 0;

    ps2_rx #(.FILTER_LEN(4), .TIMEOUT_CYCLES(200)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .code(code), .code_valid(code_valid), .is_ext(is_ext), .is_break(is_break),
        .parity_err(parity_err), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Observed events {ext, brk, code} and error pulse counts
    logic [9:0] ev_q[$];
    int   perr_cnt = 0, ferr_cnt = 0, dbl_cnt = 0;
    logic prev_pulse = 1'b0;
    time  valid_t = 0, stop_fall_t = 0;

    // Expected events from the frame-level model
    logic [9:0] exp_q[$];
    int   exp_perr = 0, exp_ferr = 0;
    logic pend_ext = 1'b0, pend_brk = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (code_valid) begin
                ev_q.push_back({is_ext, is_break, code});
                valid_t = $time;
            end
            if ((code_valid || parity_err || frame_err) && prev_pulse) dbl_cnt++;
            if (parity_err) perr_cnt++;
            if (frame_err) ferr_cnt++;
            prev_pulse = code_valid | parity_err | frame_err;
        end else begin
            prev_pulse = 1'b0;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_obs();
        @(posedge clk);
        ev_q.delete(); exp_q.delete();
        perr_cnt = 0; ferr_cnt = 0; dbl_cnt = 0;
        exp_perr = 0; exp_ferr = 0;
    endtask

    // Spec-level frame rules: errors drop prefixes, E0/F0 set flags, others emit
    task automatic model_frame(input logic [7:0] b, input bit par_ok, input bit stop_ok);
        if (!stop_ok) begin
            exp_ferr++; pend_ext = 0; pend_brk = 0;
        end else if (!par_ok) begin
            exp_perr++; pend_ext = 0; pend_brk = 0;
        end else if (b == 8'hE0) begin
            pend_ext = 1;
        end else if (b == 8'hF0) begin
            pend_brk = 1;
        end else begin
            exp_q.push_back({pend_ext, pend_brk, b});
            pend_ext = 0; pend_brk = 0;
        end
    endtask

    // Drive the first nbits of a frame; full frames also update the model
    task automatic send_frame(input logic [7:0] b, input bit par_ok, input bit stop_ok,
                              input int half, input bit glitch, input int nbits);
        logic [10:0] bits;
        logic p;
        p = par_ok ? ~(^b) : (^b);
        bits = {stop_ok, p, b, 1'b0};
        @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            if (glitch && i == 4) begin
                wait_cyc(half / 2);
                ps2_clk = 1'b0;
                wait_cyc(2);
                ps2_clk = 1'b1;
                wait_cyc(half - half / 2);
            end else begin
                wait_cyc(half);
            end
            ps2_clk = 1'b0;
            if (i == 10) stop_fall_t = $time;
            wait_cyc(half);
            ps2_clk = 1'b1;
        end
        if (nbits == 11) begin
            ps2_data = 1'b1;
            model_frame(b, par_ok, stop_ok);
            wait_cyc(half);
        end
    endtask

    task automatic test_reset();
        wait_cyc(3);
        if (code !== 8'h00) begin $display("FAIL reset_code got=%h want=00", code); bad++; end
        total++;
        if (code_valid !== 1'b0) begin $display("FAIL reset_valid got=%b want=0", code_valid); bad++; end
        total++;
        if ({is_ext, is_break} !== 2'b00) begin $display("FAIL reset_flags got=%b want=00", {is_ext, is_break}); bad++; end
        total++;
        if ({parity_err, frame_err} !== 2'b00) begin $display("FAIL reset_errs got=%b want=00", {parity_err, frame_err}); bad++; end
        total++;
        rst = 1'b0;
        wait_cyc(5);
    endtask

    task automatic test_basic();
        clear_obs();
        send_frame(8'h1C, 1, 1, 16, 0, 11);
        wait_cyc(10);
        @(posedge clk); #1;
        if (ev_q.size() !== 1) begin $display("FAIL basic_count got=%0d want=1", ev_q.size()); bad++; end
        else if (ev_q[0] !== {2'b00, 8'h1C}) begin $display("FAIL basic_event got=%h want=%h", ev_q[0], {2'b00, 8'h1C}); bad++; end
        total++;
        if (perr_cnt + ferr_cnt !== 0) begin $display("FAIL basic_errs got=%0d want=0", perr_cnt + ferr_cnt); bad++; end
        total++;
        if (valid_t - stop_fall_t < 60 || valid_t - stop_fall_t > 80) begin
            $display("FAIL basic_latency got=%0t want=60..80", valid_t - stop_fall_t); bad++;
        end
        total++;
        if (dbl_cnt !== 0) begin $display("FAIL basic_pulse_width got=%0d want=0", dbl_cnt); bad++; end
        total++;
    endtask

    task automatic test_prefixes();
        clear_obs();
        send_frame(8'hF0, 1, 1, 14, 0, 11);
        send_frame(8'h1C, 1, 1, 14, 0, 11);
        send_frame(8'hE0, 1, 1, 14, 0, 11);
        send_frame(8'hF0, 1, 1, 14, 0, 11);
        send_frame(8'h75, 1, 1, 14, 0, 11);
        send_frame(8'h1C, 1, 1, 14, 0, 11);
        send_frame(8'hF0, 1, 1, 14, 0, 11);
        send_frame(8'hF0, 1, 1, 14, 0, 11);
        send_frame(8'h29, 1, 1, 14, 0, 11);
        wait_cyc(10);
        @(posedge clk); #1;
        if (ev_q.size() !== 4) begin $display("FAIL prefix_count got=%0d want=4", ev_q.size()); bad++; end
        total++;
        for (int i = 0; i < 4 && i < ev_q.size(); i++) begin
            if (ev_q[i] !== exp_q[i]) begin $display("FAIL prefix_event%0d got=%h want=%h", i, ev_q[i], exp_q[i]); bad++; end
            total++;
        end
        if ({is_ext, is_break, code} !== {2'b01, 8'h29}) begin
            $display("FAIL prefix_hold got=%h want=%h", {is_ext, is_break, code}, {2'b01, 8'h29}); bad++;
        end
        total++;
    endtask

    task automatic test_parity();
        clear_obs();
        send_frame(8'h1C, 0, 1, 15, 0, 11);
        send_frame(8'hF0, 1, 1, 15, 0, 11);
        send_frame(8'h2C, 1, 1, 15, 0, 11);
        send_frame(8'hE0, 1, 1, 15, 0, 11);
        send_frame(8'h2C, 0, 0, 15, 0, 11);
        send_frame(8'h33, 1, 1, 15, 0, 11);
        wait_cyc(10);
        @(posedge clk); #1;
        if (perr_cnt !== 1) begin $display("FAIL parity_errs got=%0d want=1", perr_cnt); bad++; end
        total++;
        if (ferr_cnt !== 1) begin $display("FAIL parity_frame_errs got=%0d want=1", ferr_cnt); bad++; end
        total++;
        if (ev_q.size() !== 2) begin $display("FAIL parity_count got=%0d want=2", ev_q.size()); bad++; end
        else begin
            if (ev_q[0] !== {2'b01, 8'h2C}) begin $display("FAIL parity_after_err got=%h want=%h", ev_q[0], {2'b01, 8'h2C}); bad++; end
            total++;
            if (ev_q[1] !== {2'b00, 8'h33}) begin $display("FAIL stop_clears_ext got=%h want=%h", ev_q[1], {2'b00, 8'h33}); bad++; end
        end
        total++;
    endtask

    task automatic test_glitch();
        clear_obs();
        send_frame(8'hA5, 1, 1, 16, 1, 11);
        send_frame(8'h5A, 1, 1, 16, 1, 11);
        wait_cyc(10);
        @(posedge clk); #1;
        if (ev_q.size() !== 2) begin $display("FAIL glitch_count got=%0d want=2", ev_q.size()); bad++; end
        else if (ev_q[0] !== {2'b00, 8'hA5} || ev_q[1] !== {2'b00, 8'h5A}) begin
            $display("FAIL glitch_event got=%h,%h want=0a5,05a", ev_q[0], ev_q[1]); bad++;
        end
        total++;
        if (perr_cnt + ferr_cnt !== 0) begin $display("FAIL glitch_errs got=%0d want=0", perr_cnt + ferr_cnt); bad++; end
        total++;
    endtask

    task automatic run_random(input string name, input int n, input bit fixed_half);
        logic [7:0] b;
        int sel;
        clear_obs();
        for (int i = 0; i < n; i++) begin
            sel = $urandom_range(0, 9);
            b = (sel < 2) ? 8'hE0 : (sel < 4) ? 8'hF0 : 8'($urandom_range(0, 255));
            send_frame(b, $urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0,
                       fixed_half ? 12 : int'($urandom_range(12, 25)), 0, 11);
        end
        wait_cyc(10);
        @(posedge clk); #1;
        if (ev_q.size() !== exp_q.size()) begin $display("FAIL %s_count got=%0d want=%0d", name, ev_q.size(), exp_q.size()); bad++; end
        total++;
        for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
            if (ev_q[i] !== exp_q[i]) begin $display("FAIL %s_event%0d got=%h want=%h", name, i, ev_q[i], exp_q[i]); bad++; end
            total++;
        end
        if (perr_cnt !== exp_perr) begin $display("FAIL %s_parity got=%0d want=%0d", name, perr_cnt, exp_perr); bad++; end
        total++;
        if (ferr_cnt !== exp_ferr) begin $display("FAIL %s_frame got=%0d want=%0d", name, ferr_cnt, exp_ferr); bad++; end
        total++;
    endtask

    task automatic test_random();
        run_random("random", 30, 0);
    endtask

    task automatic test_back_to_back();
        run_random("b2b", 12, 1);
    endtask

`ifdef PS2_TIMEOUT_EN
    task automatic test_timeout();
        clear_obs();
        send_frame(8'h3C, 1, 1, 14, 0, 5);
        ps2_data = 1'b1;
        wait_cyc(150);
        if (ferr_cnt !== 0) begin $display("FAIL timeout_early got=%0d want=0", ferr_cnt); bad++; end
        total++;
        wait_cyc(100);
        if (ferr_cnt !== 1) begin $display("FAIL timeout_frame got=%0d want=1", ferr_cnt); bad++; end
        total++;
        pend_ext = 0; pend_brk = 0;
        send_frame(8'h1C, 1, 1, 14, 0, 11);
        wait_cyc(10);
        @(posedge clk); #1;
        if (ev_q.size() !== 1 || ev_q[0] !== {2'b00, 8'h1C}) begin
            $display("FAIL timeout_recover got=%0d events want=1 of 01c", ev_q.size()); bad++;
        end
        total++;
    endtask
`endif

    task automatic test_reset_mid();
        clear_obs();
        send_frame(8'h1C, 1, 1, 14, 0, 11);
        send_frame(8'hE0, 1, 1, 14, 0, 11);
        wait_cyc(10);
        if (code !== 8'h1C) begin $display("FAIL pre_reset_code got=%h want=1c", code); bad++; end
        total++;
        send_frame(8'h4B, 1, 1, 14, 0, 5);
        rst = 1'b1;
        #1;
        if ({code, code_valid, is_ext, is_break, parity_err, frame_err} !== 13'd0) begin
            $display("FAIL reset_mid_outputs got=%h want=0", {code, code_valid, is_ext, is_break, parity_err, frame_err}); bad++;
        end
        total++;
        ps2_data = 1'b1;
        pend_ext = 0; pend_brk = 0;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(3);
        clear_obs();
        send_frame(8'h1C, 1, 1, 14, 0, 11);
        wait_cyc(10);
        @(posedge clk); #1;
        if (ev_q.size() !== 1 || ev_q[0] !== {2'b00, 8'h1C}) begin
            $display("FAIL reset_mid_recover got=%0d events want=1 of 01c", ev_q.size()); bad++;
        end
        total++;
        if (perr_cnt + ferr_cnt !== 0) begin $display("FAIL reset_mid_errs got=%0d want=0", perr_cnt + ferr_cnt); bad++; end
        total++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_prefixes();
        test_parity();
        test_glitch();
        test_random();
        test_back_to_back();
`ifdef PS2_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute bound on run time
    initial begin
        #20ms;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
